// File: rtl/pms_port2_arbiter.sv
// pms_port2_arbiter: owns pms memory port 2. Streams a boot/reload image from
// the loader into memory, then restores the PC/RA to the image base and hands
// the port to the core's single-cycle load/store requests.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ld_start/ld_base/ld_count     start a load of ld_count words at ld_base
//   ld_valid/ld_data/ld_ready     loader word handshake (one word per cycle)
//   ld_busy, ld_done              load in progress / completion pulse
//   core_req/we/addr/wdata        core access request (granted only in RUN)
//   core_grant, core_rvalid       same-cycle grant / read data valid next cycle
//   run_en                        core may advance
//   Memsrc, MemW2, MemR2, a2_1,   pms port-2 controls, address, write data
//   write2
//   restore, RArestore            PC/RA restore strobe and value (image base)
module pms_port2_arbiter #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_start,
   input  logic [AW-1:0] ld_base,
   input  logic [AW-1:0] ld_count,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_busy,
   output logic          ld_done,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_grant,
   output logic          core_rvalid,
   output logic          run_en,
   output logic          Memsrc,
   output logic          MemW2,
   output logic          MemR2,
   output logic [AW-1:0] a2_1,
   output logic [DW-1:0] write2,
   output logic          restore,
   output logic [AW-1:0] RArestore
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] rem_q;
   logic [AW-1:0] base_q;
   logic          rvalid_q;
   logic          start_ok;

   // A new load is only accepted when no load/release is in flight.
   assign start_ok = ld_start && ((state == IDLE) || (state == RUN));

   // State, counters, latched base and read-valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr_q   <= '0;
         rem_q    <= '0;
         base_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= (state == RUN) && core_req && !core_we;
         case (state)
            IDLE, RUN: begin
               if (start_ok) begin
                  addr_q <= ld_base;
                  rem_q  <= ld_count;
                  base_q <= ld_base;
                  state  <= (ld_count == '0) ? RELEASE : LOAD;
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  addr_q <= addr_q + AW'(1);
                  rem_q  <= rem_q - AW'(1);
                  if (rem_q == AW'(1)) begin
                     state <= RELEASE;
                  end
               end
            end
            RELEASE: state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Port-2 steering and status decode; reset forces everything quiet.
   always_comb begin
      ld_ready   = 1'b0;
      ld_busy    = 1'b0;
      ld_done    = 1'b0;
      core_grant = 1'b0;
      run_en     = 1'b0;
      Memsrc     = 1'b0;
      MemW2      = 1'b0;
      MemR2      = 1'b0;
      a2_1       = '0;
      write2     = '0;
      restore    = 1'b0;
      if (!reset) begin
         case (state)
            LOAD: begin
               ld_ready = 1'b1;
               ld_busy  = 1'b1;
               if (ld_valid) begin
                  Memsrc = 1'b1;
                  MemW2  = 1'b1;
                  a2_1   = addr_q;
                  write2 = ld_data;
               end
            end
            RELEASE: begin
               ld_busy = 1'b1;
               ld_done = 1'b1;
               restore = 1'b1;
            end
            RUN: begin
               run_en = 1'b1;
               if (core_req) begin
                  core_grant = 1'b1;
                  Memsrc     = 1'b1;
                  a2_1       = core_addr;
                  if (core_we) begin
                     MemW2  = 1'b1;
                     write2 = core_wdata;
                  end else begin
                     MemR2 = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign core_rvalid = rvalid_q;
   assign RArestore   = base_q;

endmodule

// File: tb/tb_pms_port2_arbiter.sv
// Directed bench for pms_port2_arbiter with a behavioural pms port-2 memory.
// Expected memory writes and core read data are queued when stimulus is
// driven and popped when the DUT drives the port / raises core_rvalid.
module tb_pms_port2_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_start;
   logic [15:0] ld_base;
   logic [15:0] ld_count;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic        ld_busy;
   logic        ld_done;
   logic        core_req;
   logic        core_we;
   logic [15:0] core_addr;
   logic [15:0] core_wdata;
   logic        core_grant;
   logic        core_rvalid;
   logic        run_en;
   logic        Memsrc;
   logic        MemW2;
   logic        MemR2;
   logic [15:0] a2_1;
   logic [15:0] write2;
   logic        restore;
   logic [15:0] RArestore;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_wr[$];
   logic [15:0] exp_rd[$];
   logic [15:0] mem[0:65535];
   logic [15:0] memout;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   pms_port2_arbiter #(.AW(16), .DW(16)) dut (
      .clk(clk), .reset(reset),
      .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_busy(ld_busy), .ld_done(ld_done),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_grant(core_grant), .core_rvalid(core_rvalid),
      .run_en(run_en), .Memsrc(Memsrc), .MemW2(MemW2), .MemR2(MemR2),
      .a2_1(a2_1), .write2(write2), .restore(restore), .RArestore(RArestore)
   );

   // Behavioural pms port 2: write on the grant edge, registered read.
   always @(posedge clk) begin
      if (Memsrc && MemW2) mem[a2_1] <= write2;
      if (Memsrc && MemR2) memout <= mem[a2_1];
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop and compare scoreboard entries for whatever the DUT drives this cycle.
   task automatic mon();
      wr_t         w;
      logic [15:0] r;
      if (Memsrc && MemW2) begin
         n_cmp++;
         assert (exp_wr.size() > 0) else begin
            n_err++;
            $error("FAIL wr_unexpected observed=%h@%h expected=no_write", write2, a2_1);
         end
         if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(a2_1), 32'(w.a));
            chk("wr_data", 32'(write2), 32'(w.d));
         end
      end
      if (core_rvalid) begin
         n_cmp++;
         assert (exp_rd.size() > 0) else begin
            n_err++;
            $error("FAIL rd_unexpected observed=%h expected=no_rvalid", memout);
         end
         if (exp_rd.size() > 0) begin
            r = exp_rd.pop_front();
            chk("rd_data", 32'(memout), 32'(r));
         end
      end
   endtask

   task automatic mid();
      @(negedge clk);
      mon();
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; ld_start = 1'b0; ld_base = '0; ld_count = '0;
      ld_valid = 1'b0; ld_data = '0; core_req = 1'b0; core_we = 1'b0;
      core_addr = '0; core_wdata = '0;
      nxt(); nxt();

      // Reset state; core requests ignored in IDLE
      reset = 1'b0; core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0040; core_wdata = 16'h1111;
      mid();
      chk("rst_run_en", 32'(run_en), 0);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_ld_busy", 32'(ld_busy), 0);
      chk("rst_restore", 32'(restore), 0);
      chk("rst_rarestore", 32'(RArestore), 0);
      chk("rst_rvalid", 32'(core_rvalid), 0);
      chk("idle_grant", 32'(core_grant), 0);
      chk("idle_memsrc", 32'(Memsrc), 0);
      nxt();
      core_req = 1'b0;

      // 100-word load at base 0 with data 1..100
      ld_start = 1'b1; ld_base = 16'h0000; ld_count = 16'd100;
      mid(); nxt();
      ld_start = 1'b0; ld_valid = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         ld_data = 16'(i);
         exp_wr.push_back('{a: 16'(i - 1), d: 16'(i)});
         mid();
         if (i == 1 || i == 100) begin
            chk("t1_ld_ready", 32'(ld_ready), 1);
            chk("t1_run_en", 32'(run_en), 0);
         end
         nxt();
      end
      ld_valid = 1'b0;
      mid();
      chk("t1_restore", 32'(restore), 1);
      chk("t1_ld_done", 32'(ld_done), 1);
      chk("t1_rarestore", 32'(RArestore), 32'h0000);
      chk("t1_rel_run_en", 32'(run_en), 0);
      nxt();
      mid();
      chk("t1_run_en", 32'(run_en), 1);
      chk("t1_done_pulse", 32'(ld_done), 0);
      nxt();
      for (int i = 0; i < 100; i++) begin
         core_req = 1'b1; core_we = 1'b0; core_addr = 16'(i);
         exp_rd.push_back(16'(i + 1));
         mid();
         if (i == 0) chk("t1_rd_grant", 32'(core_grant), 1);
         nxt();
      end
      core_req = 1'b0;
      mid(); nxt();

      // ld_valid toggling, count 4 at base 0x0200
      ld_start = 1'b1; ld_base = 16'h0200; ld_count = 16'd4;
      mid(); nxt();
      ld_start = 1'b0;
      for (int j = 0, k = 0; j < 7; j++) begin
         ld_valid = (j % 2 == 0);
         ld_data  = 16'h1000 + 16'(k);
         if (ld_valid) begin
            exp_wr.push_back('{a: 16'h0200 + 16'(k), d: ld_data});
            k++;
         end
         mid();
         chk("t2_ld_ready", 32'(ld_ready), 1);
         nxt();
      end
      ld_valid = 1'b0;
      mid();
      chk("t2_restore", 32'(restore), 1);
      chk("t2_ld_ready_rel", 32'(ld_ready), 0);
      chk("t2_rarestore", 32'(RArestore), 32'h0200);
      nxt();
      mid();
      chk("t2_run_en", 32'(run_en), 1);
      chk("t2_ld_busy", 32'(ld_busy), 0);
      nxt();

      // Address wrap from 0xFFFE
      ld_start = 1'b1; ld_base = 16'hFFFE; ld_count = 16'd4;
      mid(); nxt();
      ld_start = 1'b0; ld_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ld_data = 16'hA0 + 16'(i);
         exp_wr.push_back('{a: 16'hFFFE + 16'(i), d: ld_data});
         mid(); nxt();
      end
      ld_valid = 1'b0;
      mid();
      chk("t3_restore", 32'(restore), 1);
      chk("t3_rarestore", 32'(RArestore), 32'hFFFE);
      nxt();

      // Core store then load at 0x0010
      core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0010; core_wdata = 16'hABCD;
      exp_wr.push_back('{a: 16'h0010, d: 16'hABCD});
      mid();
      chk("t4_st_grant", 32'(core_grant), 1);
      chk("t4_st_memr2", 32'(MemR2), 0);
      nxt();
      core_we = 1'b0;
      exp_rd.push_back(16'hABCD);
      mid();
      chk("t4_ld_grant", 32'(core_grant), 1);
      chk("t4_ld_memr2", 32'(MemR2), 1);
      chk("t4_rvalid_early", 32'(core_rvalid), 0);
      nxt();
      core_req = 1'b0;
      mid();
      chk("t4_rvalid", 32'(core_rvalid), 1);
      nxt();

      // core_req and ld_start in the same RUN cycle
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0005;
      ld_start = 1'b1; ld_base = 16'h0300; ld_count = 16'd2;
      exp_rd.push_back(16'd6);
      mid();
      chk("t5_grant", 32'(core_grant), 1);
      chk("t5_run_en", 32'(run_en), 1);
      nxt();
      ld_start = 1'b0; core_we = 1'b1; core_addr = 16'h0020; core_wdata = 16'h5555;
      mid();
      chk("t5_load_run_en", 32'(run_en), 0);
      chk("t5_load_grant", 32'(core_grant), 0);
      chk("t5_load_ready", 32'(ld_ready), 1);
      nxt();
      core_req = 1'b0; ld_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ld_data = 16'h2222 + 16'(i);
         exp_wr.push_back('{a: 16'h0300 + 16'(i), d: ld_data});
         mid(); nxt();
      end
      ld_valid = 1'b0;
      mid();
      chk("t5_restore", 32'(restore), 1);
      nxt();
      mid();
      chk("t5_run_en_back", 32'(run_en), 1);
      nxt();

      // Reset after 3 of 10 words aborts the load
      ld_start = 1'b1; ld_base = 16'h0400; ld_count = 16'd10;
      mid(); nxt();
      ld_start = 1'b0; ld_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_data = 16'h3000 + 16'(i);
         exp_wr.push_back('{a: 16'h0400 + 16'(i), d: ld_data});
         mid(); nxt();
      end
      ld_valid = 1'b0; reset = 1'b1;
      mid(); nxt();
      reset = 1'b0; ld_valid = 1'b1; ld_data = 16'hDEAD;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("t6_ld_ready", 32'(ld_ready), 0);
         chk("t6_ld_done", 32'(ld_done), 0);
         chk("t6_restore", 32'(restore), 0);
         chk("t6_run_en", 32'(run_en), 0);
         nxt();
      end
      ld_valid = 1'b0;

      // Zero-count start, then a dropped ld_start during RELEASE
      ld_start = 1'b1; ld_base = 16'h0777; ld_count = 16'd0;
      mid();
      chk("t7_idle_busy", 32'(ld_busy), 0);
      nxt();
      ld_base = 16'h0123; ld_count = 16'd5;
      mid();
      chk("t7_restore", 32'(restore), 1);
      chk("t7_ld_done", 32'(ld_done), 1);
      chk("t7_rarestore", 32'(RArestore), 32'h0777);
      nxt();
      ld_start = 1'b0;
      mid();
      chk("t7_run_en", 32'(run_en), 1);
      chk("t7_no_reload", 32'(ld_ready), 0);
      chk("t7_base_kept", 32'(RArestore), 32'h0777);
      nxt();

      chk("wr_left", 32'(exp_wr.size()), 0);
      chk("rd_left", 32'(exp_rd.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pms_port2_arbiter.md
# pms_port2_arbiter

Owns memory port 2 of the program management system (pms) in the 16-bit processor. It arbitrates that port between a boot/reload loader stream and the core's load/store requests, and holds the core off until a program image has been written. On completion it restores the PC to the image base and releases the core. It sits between the pms and the top-level control unit. It drives the pms `Memsrc`, `MemW2`, `MemR2`, `a2_1` and `write2` inputs, plus the `restore`/`RArestore` path used for the PC.

## Interface
- `AW`, 16, address width (a2_1, bases, counters)
- `DW`, 16, data width (write2, loader and core data)

- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `ld_start`  in  1  one-cycle pulse: begin a load of `ld_count` words at `ld_base`
- `ld_base`  in  AW  first memory address of image, sampled on accepted `ld_start`
- `ld_count`  in  AW  number of words, sampled on accepted `ld_start`
- `ld_valid`  in  1  loader word present on `ld_data`
- `ld_data`  in  DW  loader word
- `ld_ready`  out  1  arbiter accepts a word this cycle
- `ld_busy`  out  1  high in LOAD and RELEASE
- `ld_done`  out  1  one-cycle pulse in RELEASE
- `core_req`  in  1  core memory access request, single-cycle
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core store data
- `core_grant`  out  1  request serviced this cycle
- `core_rvalid`  out  1  read data valid on pms `Memout`, cycle after granted load
- `run_en`  out  1  core may advance; gates `writePC`/`writeRA` in the control unit
- `Memsrc`, `MemW2`, `MemR2`  out  1 each  pms port-2 controls
- `a2_1`  out  AW  pms port-2 address
- `write2`  out  DW  pms port-2 write data
- `restore`  out  1  pms PC/RA restore strobe
- `RArestore`  out  AW  restore value (latched `ld_base`)

## Operation
- States: IDLE, LOAD, RELEASE, RUN. State, address counter, remaining counter, latched base and `core_rvalid` are registered. Port-2 outputs are combinational from state and current inputs.
- IDLE: `run_en`=0 and `ld_ready`=0. `ld_start` moves to LOAD, or to RELEASE if `ld_count`==0. Core requests are ignored (`core_grant`=0).
- LOAD: `ld_ready`=1. When `ld_valid`&`ld_ready`:
  - drive `Memsrc`=1, `MemW2`=1, `a2_1`=addr, `write2`=`ld_data`;
  - increment addr modulo 2^AW (0xFFFF wraps to 0x0000);
  - decrement remaining.
  - The transfer that takes remaining to 0 moves to RELEASE.
  - `ld_valid`=0 holds everything. `ld_start` is ignored. `core_grant`=0.
- RELEASE: one cycle with `restore`=1, `RArestore`=latched base, `ld_done`=1, `ld_ready`=0. Next state is RUN.
- RUN: `run_en`=1.
  - `core_req` is granted in the same cycle (`core_grant`=1, `Memsrc`=1, `a2_1`=`core_addr`).
  - A store drives `MemW2`=1 and `write2`=`core_wdata`.
  - A load drives `MemR2`=1, and `core_rvalid`=1 on the next cycle.
- `ld_start` in RUN: the current-cycle `core_req` (if any) is still granted. Next state is LOAD (or RELEASE if count 0), and `run_en` falls the next cycle.
- When no access is active, `Memsrc`, `MemW2`, `MemR2`=0 and `a2_1`, `write2`=0.

## Timing
- Reset values: state IDLE. All outputs 0, including `run_en`, `ld_ready`, `restore`, `RArestore`, `core_rvalid`. Counters are 0.
- Reset overrides everything. Reset mid-LOAD aborts the load: no `ld_done`, no `restore`, and the words already written stay in memory.
- Load of N words with `ld_valid` held high: `ld_start` at cycle 0, writes in cycles 1..N, RELEASE in cycle N+1, `run_en`=1 from cycle N+2.
- Loader throughput is one word per cycle. The write happens in the handshake cycle, with no buffering.
- Core access latency: a write completes on the grant edge. Read data arrives one cycle after grant.
- `ld_start` in LOAD or RELEASE is dropped, not queued.

## Test plan
- Reset, `ld_start` base 0x0000, count 100, `ld_data`=1..100 continuous -> MemW2 high for cycles 1..100 with a2_1=0..99; `ld_done`/`restore` with RArestore=0x0000 in cycle 101; `run_en`=1 from cycle 102; `Memout` via core loads reads 1..100.
- Loader toggles `ld_valid` every other cycle, count 4 -> exactly 4 writes and no writes while `ld_valid`=0; RELEASE one cycle after 4th handshake.
- Base 0xFFFE, count 4 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; RArestore=0xFFFE.
- RUN, core store 0xABCD to 0x0010 then load 0x0010 -> `core_grant` same cycle each; `core_rvalid` next cycle after the load with 0xABCD on `Memout`.
- RUN, `core_req` and `ld_start` (count 2) in the same cycle -> core access granted; LOAD next cycle with `run_en`=0; `core_req` during LOAD gets `core_grant`=0.
- `reset` after 3 of 10 words -> IDLE next cycle; `ld_done`, `restore`, `run_en` stay 0. `ld_count`=0 start -> RELEASE in the next cycle, then RUN.
